display_time_controller: RTL and testbench

//  Time-of-day keeper and set-mode sequencer for the four-digit HH:MM display.

---
 rtl/display_time_controller.sv | 148 ++++++++++++++
 tb/tb_display_time_controller.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/display_time_controller.sv
// HH:MM time keeper with RUN/SET_H/SET_M sequencer, scan pacing and set-mode blink mask.
// All outputs registered (one-edge latency from button pulse); no backpressure, buttons always accepted.
module display_time_controller #(
  parameter int unsigned PRESCALE_SEC = 50_000_000,
  parameter int unsigned SCAN_DIV     = 50_000,
  parameter int unsigned BLINK_DIV    = 25_000_000
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       btn_mode,
  input  logic       btn_inc,
  output logic [4:0] ore,
  output logic [5:0] minute,
  output logic [3:0] blank,
  output logic [1:0] mode,
  output logic       scan_en,
  output logic       sec_tick
);

  localparam int PW = $clog2(PRESCALE_SEC);
  localparam int SW = $clog2(SCAN_DIV);
  localparam int BW = $clog2(BLINK_DIV);
  localparam logic [PW-1:0] PRESC_LAST = PW'(PRESCALE_SEC - 1);
  localparam logic [SW-1:0] SCAN_LAST  = SW'(SCAN_DIV - 1);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_DIV - 1);

  typedef enum logic [1:0] {
    RUN   = 2'b00,
    SET_H = 2'b01,
    SET_M = 2'b10
  } mode_e;

  mode_e         mode_q, mode_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [5:0]    sec_q, sec_d;
  logic [5:0]    min_q, min_d;
  logic [4:0]    ore_q, ore_d;
  logic [SW-1:0] scan_cnt_q, scan_cnt_d;
  logic          scan_q, scan_d;
  logic [BW-1:0] blink_cnt_q, blink_cnt_d;
  logic          phase_q, phase_d;
  logic [3:0]    blank_q, blank_d;
  logic          tick_q, tick_d;
  logic          inc_ok;

  always_comb begin
    mode_d      = mode_q;
    presc_d     = presc_q;
    sec_d       = sec_q;
    min_d       = min_q;
    ore_d       = ore_q;
    blink_cnt_d = blink_cnt_q;
    phase_d     = phase_q;
    blank_d     = 4'b0000;
    // A simultaneous mode press wins and the increment is dropped.
    inc_ok      = btn_inc && !btn_mode && (mode_q != RUN);
    tick_d      = (mode_q == RUN) && !btn_mode && (presc_q == PRESC_LAST);

    if (btn_mode) begin
      case (mode_q)
        RUN:     mode_d = SET_H;
        SET_H:   mode_d = SET_M;
        default: mode_d = RUN;
      endcase
    end

    if ((mode_q != RUN) || (mode_d != RUN)) begin
      presc_d = '0;
      sec_d   = '0;
    end else if (tick_d) begin
      presc_d = '0;
      if (sec_q == 6'd59) begin
        sec_d = '0;
        if (min_q == 6'd59) begin
          min_d = '0;
          ore_d = (ore_q == 5'd23) ? 5'd0 : ore_q + 5'd1;
        end else begin
          min_d = min_q + 6'd1;
        end
      end else begin
        sec_d = sec_q + 6'd1;
      end
    end else begin
      presc_d = presc_q + PW'(1);
    end

    if (inc_ok) begin
      if (mode_q == SET_H) ore_d = (ore_q == 5'd23) ? 5'd0 : ore_q + 5'd1;
      else                 min_d = (min_q == 6'd59) ? 6'd0 : min_q + 6'd1;
    end

    // Restart blink on any edit so the touched field shows immediately.
    if (btn_mode || inc_ok) begin
      blink_cnt_d = '0;
      phase_d     = 1'b0;
    end else if (blink_cnt_q == BLINK_LAST) begin
      blink_cnt_d = '0;
      phase_d     = ~phase_q;
    end else begin
      blink_cnt_d = blink_cnt_q + BW'(1);
    end

    case (mode_d)
      SET_H:   blank_d = {phase_d, phase_d, 2'b00};
      SET_M:   blank_d = {2'b00, phase_d, phase_d};
      default: blank_d = 4'b0000;
    endcase

    scan_d     = (scan_cnt_q == SCAN_LAST);
    scan_cnt_d = scan_d ? '0 : scan_cnt_q + SW'(1);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      mode_q      <= RUN;
      presc_q     <= '0;
      sec_q       <= '0;
      min_q       <= '0;
      ore_q       <= '0;
      scan_cnt_q  <= '0;
      scan_q      <= 1'b0;
      blink_cnt_q <= '0;
      phase_q     <= 1'b0;
      blank_q     <= 4'b0000;
      tick_q      <= 1'b0;
    end else begin
      mode_q      <= mode_d;
      presc_q     <= presc_d;
      sec_q       <= sec_d;
      min_q       <= min_d;
      ore_q       <= ore_d;
      scan_cnt_q  <= scan_cnt_d;
      scan_q      <= scan_d;
      blink_cnt_q <= blink_cnt_d;
      phase_q     <= phase_d;
      blank_q     <= blank_d;
      tick_q      <= tick_d;
    end
  end

  assign ore      = ore_q;
  assign minute   = min_q;
  assign blank    = blank_q;
  assign mode     = mode_q;
  assign scan_en  = scan_q;
  assign sec_tick = tick_q;

endmodule

// File: tb/tb_display_time_controller.sv
// Scoreboard bench for display_time_controller with small prescalers.
module tb_display_time_controller;

  logic       clock;
  logic       reset_n;
  logic       btn_mode;
  logic       btn_inc;
  logic [4:0] ore;
  logic [5:0] minute;
  logic [3:0] blank;
  logic [1:0] mode;
  logic       scan_en;
  logic       sec_tick;

  typedef struct packed {
    logic [4:0] ore;
    logic [5:0] minute;
    logic [1:0] mode;
    logic [3:0] blank;
  } st_t;

  st_t  sb[$];
  int   sb_bit[$];
  int   n_chk  = 0;
  int   n_fail = 0;

  display_time_controller #(
    .PRESCALE_SEC(4),
    .SCAN_DIV    (3),
    .BLINK_DIV   (5)
  ) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .btn_mode(btn_mode),
    .btn_inc (btn_inc),
    .ore     (ore),
    .minute  (minute),
    .blank   (blank),
    .mode    (mode),
    .scan_en (scan_en),
    .sec_tick(sec_tick)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic st_t snap();
    st_t s;
    s.ore = ore; s.minute = minute; s.mode = mode; s.blank = blank;
    return s;
  endfunction

  function automatic st_t mk(input int h, input int m, input int md, input int bl);
    st_t s;
    s.ore = 5'(h); s.minute = 6'(m); s.mode = 2'(md); s.blank = 4'(bl);
    return s;
  endfunction

  task automatic do_reset();
    btn_mode = 1'b0;
    btn_inc  = 1'b0;
    reset_n  = 1'b0;
    repeat (2) @(posedge clock);
    #1 reset_n = 1'b1;
  endtask

  task automatic pulse(input logic m, input logic i);
    btn_mode = m;
    btn_inc  = i;
    @(posedge clock);
    #1;
    btn_mode = 1'b0;
    btn_inc  = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic test_reset();
    st_t got, exp;
    btn_mode = 1'b0;
    btn_inc  = 1'b0;
    reset_n  = 1'b0;
    sb.push_back(mk(0, 0, 0, 0));
    #3;
    got = snap(); exp = sb.pop_front(); n_chk++;
    if (got !== exp || scan_en !== 1'b0 || sec_tick !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_state: got %h:%h mode=%b blank=%b scan=%b tick=%b, want %h:%h mode=%b blank=%b scan=0 tick=0",
               got.ore, got.minute, got.mode, got.blank, scan_en, sec_tick, exp.ore, exp.minute, exp.mode, exp.blank);
    end
    @(posedge clock);
    #1 reset_n = 1'b1;
  endtask

  task automatic test_run_minute();
    st_t got, exp;
    int  ticks = 0;
    do_reset();
    for (int i = 1; i <= 240; i++) begin
      @(posedge clock);
      #1;
      if (sec_tick === 1'b1) ticks++;
      if (i == 239) begin
        sb.push_back(mk(0, 0, 0, 0));
        got = snap(); exp = sb.pop_front(); n_chk++;
        if (got !== exp) begin
          n_fail++;
          $display("FAIL run_before_carry: got %0d:%0d want %0d:%0d", got.ore, got.minute, exp.ore, exp.minute);
        end
      end
    end
    sb.push_back(mk(0, 1, 0, 0));
    got = snap(); exp = sb.pop_front(); n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL run_minute: got %0d:%0d mode=%b want %0d:%0d mode=%b", got.ore, got.minute, got.mode, exp.ore, exp.minute, exp.mode);
    end
    sb_bit.push_back(60);
    n_chk++;
    if (ticks !== sb_bit.pop_front()) begin
      n_fail++;
      $display("FAIL sec_tick_count: got %0d want 60", ticks);
    end
  endtask

  task automatic test_set_and_rollover();
    st_t got, exp;
    do_reset();
    pulse(1'b1, 1'b0);
    sb.push_back(mk(0, 0, 1, 0));
    got = snap(); exp = sb.pop_front(); n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL enter_set_h: got mode=%b blank=%b want mode=%b blank=%b", got.mode, got.blank, exp.mode, exp.blank);
    end
    repeat (23) pulse(1'b0, 1'b1);
    pulse(1'b1, 1'b0);
    repeat (59) pulse(1'b0, 1'b1);
    pulse(1'b1, 1'b0);
    sb.push_back(mk(23, 59, 0, 0));
    got = snap(); exp = sb.pop_front(); n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL set_23_59: got %0d:%0d mode=%b want %0d:%0d mode=%b", got.ore, got.minute, got.mode, exp.ore, exp.minute, exp.mode);
    end
    idle(239);
    sb.push_back(mk(23, 59, 0, 0));
    got = snap(); exp = sb.pop_front(); n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL hold_23_59: got %0d:%0d want %0d:%0d", got.ore, got.minute, exp.ore, exp.minute);
    end
    idle(1);
    sb.push_back(mk(0, 0, 0, 0));
    got = snap(); exp = sb.pop_front(); n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL day_rollover: got %0d:%0d want %0d:%0d", got.ore, got.minute, exp.ore, exp.minute);
    end
  endtask

  task automatic test_blink();
    st_t got, exp;
    do_reset();
    pulse(1'b1, 1'b0);
    for (int i = 0; i < 5; i++) sb.push_back(mk(0, 0, 1, 4'b0000));
    sb.push_back(mk(0, 0, 1, 4'b1100));
    for (int i = 0; i < 6; i++) begin
      if (i > 0) idle(1);
      got = snap(); exp = sb.pop_front(); n_chk++;
      if (got !== exp) begin
        n_fail++;
        $display("FAIL blink_set_h[%0d]: got blank=%b mode=%b want blank=%b mode=%b", i, got.blank, got.mode, exp.blank, exp.mode);
      end
    end
    pulse(1'b0, 1'b1);
    sb.push_back(mk(1, 0, 1, 4'b0000));
    got = snap(); exp = sb.pop_front(); n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL blink_restart_inc: got %0d blank=%b want %0d blank=%b", got.ore, got.blank, exp.ore, exp.blank);
    end
    pulse(1'b1, 1'b0);
    idle(5);
    sb.push_back(mk(1, 0, 2, 4'b0011));
    got = snap(); exp = sb.pop_front(); n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL blink_set_m: got blank=%b mode=%b want blank=%b mode=%b", got.blank, got.mode, exp.blank, exp.mode);
    end
  endtask

  task automatic test_mode_inc_same_cycle();
    st_t got, exp;
    do_reset();
    pulse(1'b1, 1'b0);
    repeat (5) pulse(1'b0, 1'b1);
    pulse(1'b1, 1'b1);
    sb.push_back(mk(5, 0, 2, 0));
    got = snap(); exp = sb.pop_front(); n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL mode_inc_same: got %0d:%0d mode=%b want %0d:%0d mode=%b", got.ore, got.minute, got.mode, exp.ore, exp.minute, exp.mode);
    end
    pulse(1'b0, 1'b1);
    pulse(1'b1, 1'b0);
    pulse(1'b0, 1'b1);
    sb.push_back(mk(5, 1, 0, 0));
    got = snap(); exp = sb.pop_front(); n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL inc_ignored_run: got %0d:%0d mode=%b want %0d:%0d mode=%b", got.ore, got.minute, got.mode, exp.ore, exp.minute, exp.mode);
    end
  endtask

  task automatic test_minute_wrap_and_reset();
    st_t  got, exp;
    logic saw_tick = 1'b0;
    do_reset();
    pulse(1'b1, 1'b0);
    repeat (3) pulse(1'b0, 1'b1);
    pulse(1'b1, 1'b0);
    repeat (59) pulse(1'b0, 1'b1);
    pulse(1'b0, 1'b1);
    sb.push_back(mk(3, 0, 2, 0));
    got = snap(); exp = sb.pop_front(); n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL minute_wrap_no_carry: got %0d:%0d blank=%b want %0d:%0d blank=%b", got.ore, got.minute, got.blank, exp.ore, exp.minute, exp.blank);
    end
    for (int i = 0; i < 20; i++) begin
      idle(1);
      if (sec_tick !== 1'b0) saw_tick = 1'b1;
    end
    sb.push_back(mk(3, 0, 2, 0));
    got = snap(); exp = sb.pop_front(); n_chk++;
    if (got.ore !== exp.ore || got.minute !== exp.minute || got.mode !== exp.mode || saw_tick !== 1'b0) begin
      n_fail++;
      $display("FAIL frozen_in_set: got %0d:%0d mode=%b tick_seen=%b want %0d:%0d mode=%b tick_seen=0",
               got.ore, got.minute, got.mode, saw_tick, exp.ore, exp.minute, exp.mode);
    end
    #2 reset_n = 1'b0;
    sb.push_back(mk(0, 0, 0, 0));
    #1;
    got = snap(); exp = sb.pop_front(); n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL reset_mid_set: got %0d:%0d mode=%b blank=%b want 0:0 mode=00 blank=0000", got.ore, got.minute, got.mode, got.blank);
    end
    @(posedge clock);
    #1 reset_n = 1'b1;
    idle(4);
    sb.push_back(mk(0, 0, 0, 0));
    got = snap(); exp = sb.pop_front(); n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL after_reset_run: got %0d:%0d mode=%b want 0:0 mode=00", got.ore, got.minute, got.mode);
    end
  endtask

  task automatic test_scan();
    int prev = 0;
    do_reset();
    for (int i = 1; i <= 45; i++) begin
      btn_mode = 1'($urandom_range(0, 1));
      btn_inc  = 1'($urandom_range(0, 1));
      sb_bit.push_back((i % 3 == 0) ? 1 : 0);
      @(posedge clock);
      #1;
      n_chk++;
      if (int'(scan_en) !== sb_bit.pop_front() || (prev == 1 && scan_en === 1'b1)) begin
        n_fail++;
        $display("FAIL scan_en[%0d]: got %b want %0d", i, scan_en, (i % 3 == 0) ? 1 : 0);
      end
      prev = int'(scan_en);
    end
    btn_mode = 1'b0;
    btn_inc  = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    btn_mode = 1'b0;
    btn_inc  = 1'b0;
    reset_n  = 1'b0;
    test_reset();
    test_run_minute();
    test_set_and_rollover();
    test_blink();
    test_mode_inc_same_cycle();
    test_minute_wrap_and_reset();
    test_scan();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
